mult_host: RTL and testbench
============================

# mult_host

Host-side sequencer for the normalize/shift multiplier core. It accepts operand pairs on a valid/ready input channel and drives the core's `start`/`Done` handshake: `start` is held high for a programmable number of cycles, then released, which launches the core. It captures the core result together with a busy-cycle latency count and presents both on a valid/ready output channel. It sits between the system or testbench side and the multiplier top level. The multiplier is the responder; this block is the initiator.

## Interface
Parameters:
- `N`, 8, operand width; the result is `2N` bits.
- `START_CYCLES`, 2, number of cycles `start` is held high (≥1).
- `CW`, 8, width of the latency counter.
- `TIMEOUT`, 255, BUSY-cycle limit; used only when `MULT_HOST_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: block can accept operands.
- `in_a` in N: operand A.
- `in_b` in N: operand B.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer takes the result.
- `out_result` out 2N: captured product.
- `out_cycles` out CW: BUSY cycles until `Done`; saturating.
- `out_timeout` out 1: result was produced by timeout, not by the core.
- `start` out 1: to the core.
- `core_a` out N: operand A to the core.
- `core_b` out N: operand B to the core.
- `Done` in 1: one-cycle completion pulse from the core.
- `core_result` in 2N: product, valid in the cycle `Done` is 1.

## Operation
- The state machine has four states: IDLE, START, BUSY and HOLD. Encoding is defined in the package.
- **IDLE**
  - `in_ready=1`.
  - When `in_valid`: latch `in_a`/`in_b` into `core_a`/`core_b`, clear the start counter and latency counter, go to START.
- **START**
  - `start=1`; the start counter increments.
  - After `START_CYCLES` cycles in START, go to BUSY.
  - `Done` is ignored in this state.
- **BUSY**
  - `start=0`; the latency counter increments each cycle and saturates at all-ones.
  - When `Done`: capture `core_result` into `out_result` and the count into `out_cycles`, set `out_timeout=0`, go to HOLD.
- **HOLD**
  - `out_valid=1`; outputs are stable.
  - When `out_ready`: go to IDLE.
- `core_a`/`core_b` stay stable from acceptance until the next acceptance, so the core sees constant operands when `start` falls and loads them.
- In IDLE, `out_*` keep their last captured values.

## Timing
- Reset (`rst=0`, async):
  - State = IDLE.
  - `start`, `out_valid`, `out_timeout` = 0; `in_ready` = 1.
  - `out_result`, `out_cycles`, `core_a`, `core_b`, and both counters = 0.
- Let the accept cycle be t0. Then:
  - `start` is high for cycles t0+1 … t0+START_CYCLES.
  - BUSY begins at t0+START_CYCLES+1.
  - If `Done` arrives at BUSY cycle k (the first BUSY cycle is k=1), `out_valid` rises the next cycle and `out_cycles = k`.
- `in_ready` is 1 only in IDLE. There is no bypass: an `in_valid` in the same cycle as the HOLD→IDLE handshake is accepted one cycle later at the earliest.
- `out_valid` depends only on state; `in_ready` does not depend combinationally on `out_ready`.
- Reset asserted mid-operation drops `start` immediately. The core must be reset by its own reset.
- `Done` outside BUSY has no effect.

## Configuration
- `MULT_HOST_TIMEOUT_EN` defined:
  - In BUSY, when the latency count reaches `TIMEOUT` without `Done`, go to HOLD with `out_result=0`, `out_cycles=TIMEOUT`, `out_timeout=1`.
  - If `Done` arrives in the same cycle as the limit, `Done` wins and `out_timeout=0`.
- `MULT_HOST_TIMEOUT_EN` undefined:
  - BUSY waits indefinitely for `Done`.
  - `out_timeout` is tied to 0; the port stays present.

## Structure
- Shared package `mult_pkg`: state enum/localparams (IDLE/START/BUSY/HOLD), default `N`, `CW`, `START_CYCLES`.
- One sub-module, `sat_counter`:
  - Parameterized width.
  - Inputs `clr` and `inc`; holds at all-ones.
  - Used for the latency count. The start counter is a plain local counter.

## Test plan
- Reset, then `in_a=12`, `in_b=10`. The core model pulses `Done` at BUSY cycle 20 with `core_result=120`. Required: `start` high for exactly 2 cycles; `out_valid` with `out_result=16'd120`, `out_cycles=20`, `out_timeout=0`.
- Hold `out_ready=0` for 5 cycles in HOLD while `in_valid=1` with new operands. Required: outputs stable, `in_ready=0`, new pair accepted one cycle after the `out_ready` handshake.
- Pulse `Done` during START. Required: ignored; the result is taken only from the later BUSY `Done`.
- With `CW=4`, `Done` at BUSY cycle 30. Required: `out_cycles=4'hF`.
- With `MULT_HOST_TIMEOUT_EN`, `TIMEOUT=50`, no `Done`. Required: HOLD with `out_result=0`, `out_cycles=50`, `out_timeout=1`. Repeat with `Done` at cycle 50: required `out_timeout=0`.
- Assert `rst=0` mid-START. Required: `start=0` asynchronously, `in_ready=1`, `out_valid=0`.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier host sequencer (mult_host).
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int unsigned DEF_N            = 8;
    localparam int unsigned DEF_CW           = 8;
    localparam int unsigned DEF_START_CYCLES = 2;
    localparam int unsigned DEF_TIMEOUT      = 255;

    // Bits needed to hold the values 0..maxVal (at least one bit).
    function automatic int unsigned cntWidth(input int unsigned maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/mult_host_if.sv
// Host-side bundle for mult_host: operand input channel, result output channel and core start/Done handshake.
interface mult_host_if
    import mult_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned CW = DEF_CW
);
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_a;
    logic [N-1:0]    in_b;
    logic            out_valid;
    logic            out_ready;
    logic [2*N-1:0]  out_result;
    logic [CW-1:0]   out_cycles;
    logic            out_timeout;
    logic            start;
    logic [N-1:0]    core_a;
    logic [N-1:0]    core_b;
    logic            Done;
    logic [2*N-1:0]  core_result;

    // The sequencer itself.
    modport master (
        input  in_valid, in_a, in_b, out_ready, Done, core_result,
        output in_ready, out_valid, out_result, out_cycles, out_timeout,
               start, core_a, core_b
    );

    // Producer/consumer plus multiplier core around the sequencer.
    modport slave (
        output in_valid, in_a, in_b, out_ready, Done, core_result,
        input  in_ready, out_valid, out_result, out_cycles, out_timeout,
               start, core_a, core_b
    );

endinterface

// File: rtl/mult_host_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mult_host.sv
// Host sequencer for the multiplier core: start pulse, latency count, result capture.
// Optional BUSY timeout is built in when MULT_HOST_TIMEOUT_EN is defined.
module mult_host
    import mult_pkg::*;
#(
    parameter int unsigned N            = DEF_N,
    parameter int unsigned START_CYCLES = DEF_START_CYCLES,
    parameter int unsigned CW           = DEF_CW,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
    input  logic      clk,
    input  logic      rst,
    mult_host_if.master bus
);

    localparam int unsigned    SW         = cntWidth(START_CYCLES);
    localparam logic [SW-1:0]  START_LAST = SW'(START_CYCLES - 1);

`ifdef MULT_HOST_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t          state;
    state_t          stateNext;
    logic [SW-1:0]   startCnt;
    logic [CW-1:0]   latCnt;
    logic            latInc;
    logic            accept;
    logic            capture;
    logic            timedOut;
    logic            timeoutHit;
    logic [N-1:0]    coreA;
    logic [N-1:0]    coreB;
    logic [2*N-1:0]  outResult;
    logic [CW-1:0]   outCycles;

    // The latency counter also steps on the START->BUSY edge, so during
    // BUSY cycle k it already reads k and can be captured directly.
    sat_counter #(
        .W (CW)
    ) u_latCnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .inc   (latInc),
        .count (latCnt)
    );

    assign timeoutHit = TIMEOUT_EN && (32'(latCnt) == 32'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        capture   = 1'b0;
        timedOut  = 1'b0;
        latInc    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    stateNext = START;
                end
            end
            START: begin
                if (startCnt == START_LAST) begin
                    latInc    = 1'b1;
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                latInc = 1'b1;
                if (bus.Done) begin
                    capture   = 1'b1;
                    stateNext = HOLD;
                end else if (timeoutHit) begin
                    timedOut  = 1'b1;
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coreA     <= '0;
            coreB     <= '0;
            startCnt  <= '0;
            outResult <= '0;
            outCycles <= '0;
        end else begin
            if (accept) begin
                coreA    <= bus.in_a;
                coreB    <= bus.in_b;
                startCnt <= '0;
            end else if (state == START) begin
                startCnt <= startCnt + 1'b1;
            end
            if (capture) begin
                outResult <= bus.core_result;
                outCycles <= latCnt;
            end else if (timedOut) begin
                outResult <= '0;
                outCycles <= latCnt;
            end
        end
    end

`ifdef MULT_HOST_TIMEOUT_EN
    logic outTimeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outTimeout <= 1'b0;
        end else if (capture) begin
            outTimeout <= 1'b0;
        end else if (timedOut) begin
            outTimeout <= 1'b1;
        end
    end

    assign bus.out_timeout = outTimeout;
`else
    assign bus.out_timeout = 1'b0;
`endif

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == HOLD);
    assign bus.start      = (state == START);
    assign bus.core_a     = coreA;
    assign bus.core_b     = coreB;
    assign bus.out_result = outResult;
    assign bus.out_cycles = outCycles;

endmodule

// File: tb/tb_mult_host.sv
// Self-checking bench for mult_host: vector table plus scoreboard, with CW=4 and reset corner sequences.
module tb_mult_host;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          doneK;
        bit          early;
        int          hold;
        logic [15:0] expRes;
        logic [7:0]  expCyc;
        logic        expTo;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [7:0]  cyc;
        logic        to;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs[5];
    exp_t sb[$];

    mult_host_if #(.N(8), .CW(8)) busA ();
    mult_host_if #(.N(8), .CW(4)) busB ();

    mult_host #(
        .N            (8),
        .START_CYCLES (2),
        .CW           (8),
        .TIMEOUT      (50)
    ) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    mult_host #(
        .N            (8),
        .START_CYCLES (2),
        .CW           (4),
        .TIMEOUT      (255)
    ) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One transaction on busA; nA/nB are offered during any HOLD stall.
    task automatic doOp(input vec_t v, input logic [7:0] nA, input logic [7:0] nB);
        bit          got;
        exp_t        e;
        logic [15:0] prod;
        prod = 16'(v.a) * 16'(v.b);
        busA.in_valid = 1'b1;
        busA.in_a     = v.a;
        busA.in_b     = v.b;
        for (int w = 0; w < 10 && !busA.in_ready; w++) @(negedge clk);
        check("in_ready_idle", busA.in_ready, 1);
        sb.push_back('{v.expRes, v.expCyc, v.expTo});
        @(negedge clk);
        busA.in_valid = 1'b0;
        check("core_a", busA.core_a, v.a);
        check("core_b", busA.core_b, v.b);
        for (int i = 1; i <= 2; i++) begin
            check("start_high", busA.start, 1);
            busA.Done        = v.early && (i == 1);
            busA.core_result = 16'hBEEF;
            @(negedge clk);
        end
        busA.Done = 1'b0;
        check("start_low_busy", busA.start, 0);
        got = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            if (busA.out_valid) begin
                got = 1'b1;
                break;
            end
            busA.Done        = (k == v.doneK);
            busA.core_result = (k == v.doneK) ? prod : 16'($urandom);
            @(negedge clk);
        end
        busA.Done = 1'b0;
        check("hold_reached", got, 1);
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            check("out_result", busA.out_result, e.res);
            check("out_cycles", busA.out_cycles, e.cyc);
            check("out_timeout", busA.out_timeout, e.to);
            check("in_ready_hold", busA.in_ready, 0);
            for (int h = 0; h < v.hold; h++) begin
                busA.in_valid = 1'b1;
                busA.in_a     = nA;
                busA.in_b     = nB;
                @(negedge clk);
                check("stall_valid", busA.out_valid, 1);
                check("stall_in_ready", busA.in_ready, 0);
                check("stall_result", busA.out_result, e.res);
                check("stall_cycles", busA.out_cycles, e.cyc);
            end
            busA.out_ready = 1'b1;
            @(negedge clk);
            busA.out_ready = 1'b0;
            check("idle_out_valid", busA.out_valid, 0);
            check("idle_in_ready", busA.in_ready, 1);
            check("no_bypass_start", busA.start, 0);
            check("idle_keep_result", busA.out_result, e.res);
        end
    endtask

    initial begin
        bit gotB;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        busA.in_valid = 1'b0; busA.in_a = '0; busA.in_b = '0;
        busA.out_ready = 1'b0; busA.Done = 1'b0; busA.core_result = '0;
        busB.in_valid = 1'b0; busB.in_a = '0; busB.in_b = '0;
        busB.out_ready = 1'b0; busB.Done = 1'b0; busB.core_result = '0;

        vecs[0] = '{8'd12, 8'd10, 20, 1'b0, 5, 16'd120, 8'd20, 1'b0};
        vecs[1] = '{8'd255, 8'd255, 1, 1'b1, 0, 16'd65025, 8'd1, 1'b0};
        vecs[2] = '{8'd7, 8'd9, 3, 1'b1, 3, 16'd63, 8'd3, 1'b0};
`ifdef MULT_HOST_TIMEOUT_EN
        vecs[3] = '{8'd3, 8'd4, 0, 1'b0, 0, 16'd0, 8'd50, 1'b1};
`else
        vecs[3] = '{8'd3, 8'd4, 120, 1'b0, 0, 16'd12, 8'd120, 1'b0};
`endif
        vecs[4] = '{8'd5, 8'd6, 50, 1'b0, 0, 16'd30, 8'd50, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_in_ready", busA.in_ready, 1);
        check("rst_start", busA.start, 0);
        check("rst_out_valid", busA.out_valid, 0);
        check("rst_out_timeout", busA.out_timeout, 0);
        check("rst_out_result", busA.out_result, 0);
        check("rst_out_cycles", busA.out_cycles, 0);
        check("rst_core_a", busA.core_a, 0);
        check("rst_core_b", busA.core_b, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            if (i < 4) doOp(vecs[i], vecs[i+1].a, vecs[i+1].b);
            else       doOp(vecs[i], 8'd0, 8'd0);
        end

        // Reset in the middle of START must drop start without a clock edge.
        busA.in_valid = 1'b1;
        busA.in_a     = 8'd1;
        busA.in_b     = 8'd1;
        @(negedge clk);
        busA.in_valid = 1'b0;
        check("mid_start_high", busA.start, 1);
        #1 rst = 1'b0;
        #1;
        check("async_start", busA.start, 0);
        check("async_in_ready", busA.in_ready, 1);
        check("async_out_valid", busA.out_valid, 0);
        check("async_core_a", busA.core_a, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_start", busA.start, 0);

        // Narrow latency counter saturates at all-ones.
        busB.in_valid = 1'b1;
        busB.in_a     = 8'd2;
        busB.in_b     = 8'd3;
        @(negedge clk);
        busB.in_valid = 1'b0;
        check("b_start", busB.start, 1);
        repeat (2) @(negedge clk);
        gotB = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (busB.out_valid) begin
                gotB = 1'b1;
                break;
            end
            busB.Done        = (k == 30);
            busB.core_result = (k == 30) ? 16'd6 : 16'hFFFF;
            @(negedge clk);
        end
        busB.Done = 1'b0;
        check("b_hold_reached", gotB, 1);
        check("b_out_cycles_sat", busB.out_cycles, 4'hF);
        check("b_out_result", busB.out_result, 16'd6);
        check("b_out_timeout", busB.out_timeout, 0);
        busB.out_ready = 1'b1;
        @(negedge clk);
        busB.out_ready = 1'b0;
        check("b_idle", busB.in_ready, 1);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
